sd_nios2_gen2_0_cpu_mul_ctrl: RTL and testbench

SD_NIOS2_GEN2_0_CPU_MUL_CTRL -- requirements
Module: SD_nios2_gen2_0_cpu_mul_ctrl

---
 rtl/sd_nios2_gen2_0_cpu_mul_ctrl.sv | 178 +++++++++++++++++
 tb/tb_sd_nios2_gen2_0_cpu_mul_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_nios2_gen2_0_cpu_mul_ctrl.sv
// ---------------------------------------------------------------------------
// sd_nios2_gen2_0_cpu_mul_ctrl
//
// Sequences a 32x32 unsigned multiply through an external 16x16 multiplier
// cell that returns three partial products (lo*lo, A.lo*B.hi, A.hi*B.lo) one
// cycle after its enable. The low word needs one cell pass (3-cycle latency).
// The high word needs a second pass for A.hi*B.hi (5-cycle latency).
//
// Build option:
//   SD_MUL_CTRL_HI_EN  defined   : req_op = 1 returns bits [63:32] of A*B.
//                      undefined : req_op is ignored and the low word is
//                                  always returned; no second pass exists.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_src1/req_src2     unsigned operands A and B
//   req_op                0 = low word, 1 = high word
//   req_tag               opaque id returned on rsp_tag
//   rsp_valid/rsp_ready   response handshake; data/tag held until taken
//   rsp_data, rsp_tag     result and the tag of its request
//   cell_src1/cell_src2   operands driven to the multiplier cell
//   cell_en               one-cycle cell register enable
//   cell_p1/p2/p3         cell products, valid one cycle after cell_en
// ---------------------------------------------------------------------------
module sd_nios2_gen2_0_cpu_mul_ctrl #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_src1,
   input  logic [31:0]      req_src2,
   input  logic             req_op,
   input  logic [TAG_W-1:0] req_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [31:0]      cell_src1,
   output logic [31:0]      cell_src2,
   output logic             cell_en,
   input  logic [31:0]      cell_p1,
   input  logic [31:0]      cell_p2,
   input  logic [31:0]      cell_p3
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ISSUE1 = 3'd1;
   localparam logic [2:0] S_WAIT1  = 3'd2;
   localparam logic [2:0] S_RESP   = 3'd3;
`ifdef SD_MUL_CTRL_HI_EN
   localparam logic [2:0] S_ISSUE2 = 3'd4;
   localparam logic [2:0] S_WAIT2  = 3'd5;
`endif

   logic [2:0]       r_state;
   logic [TAG_W-1:0] r_tag;
   logic             r_rsp_valid;
   logic [31:0]      r_rsp_data;
   logic [TAG_W-1:0] r_rsp_tag;
   logic [31:0]      r_cell_src1;
   logic [31:0]      r_cell_src2;
   logic             r_cell_en;

   // Cross terms summed at full width; the 33rd bit matters for the high word.
   logic [32:0]      w_mid;
   logic [31:0]      w_lo;

   assign w_mid = {1'b0, cell_p2} + {1'b0, cell_p3};
   // Only mid[15:0] reaches the low word once shifted left by 16.
   assign w_lo  = cell_p1 + {w_mid[15:0], 16'h0};

`ifdef SD_MUL_CTRL_HI_EN
   logic             r_op;
   logic [31:0]      r_p1a;
   logic [32:0]      r_mid;
   logic [63:0]      w_full;
   logic [31:0]      w_unused_full_lo;

   // In WAIT2 cell_p1 carries A.hi*B.hi (P1b); the cross terms were zero.
   assign w_full = {cell_p1, 32'h0} + {15'h0, r_mid, 16'h0} + {32'h0, r_p1a};
   assign w_unused_full_lo = w_full[31:0];
`else
   logic             w_unused_op;
   logic [16:0]      w_unused_mid_hi;

   assign w_unused_op     = req_op;
   assign w_unused_mid_hi = w_mid[32:16];
`endif

   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_tag   = r_rsp_tag;
   assign cell_src1 = r_cell_src1;
   assign cell_src2 = r_cell_src2;
   assign cell_en   = r_cell_en;

   // NOTE: all state here uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_tag       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_tag   <= '0;
         r_cell_src1 <= '0;
         r_cell_src2 <= '0;
         r_cell_en   <= 1'b0;
`ifdef SD_MUL_CTRL_HI_EN
         r_op        <= 1'b0;
         r_p1a       <= '0;
         r_mid       <= '0;
`endif
      end else begin
         // NOTE: default low here makes cell_en a one-cycle pulse wherever it is set.
         r_cell_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  // Operands go straight into the cell operand registers, which
                  // then hold A/B until the optional second pass needs A.hi/B.hi.
                  r_cell_src1 <= req_src1;
                  r_cell_src2 <= req_src2;
                  r_cell_en   <= 1'b1;
                  r_tag       <= req_tag;
`ifdef SD_MUL_CTRL_HI_EN
                  r_op        <= req_op;
`endif
                  r_state     <= S_ISSUE1;
               end
            end
            S_ISSUE1: r_state <= S_WAIT1;
            S_WAIT1: begin
`ifdef SD_MUL_CTRL_HI_EN
               if (r_op) begin
                  r_p1a       <= cell_p1;
                  r_mid       <= w_mid;
                  r_cell_src1 <= {16'h0, r_cell_src1[31:16]};
                  r_cell_src2 <= {16'h0, r_cell_src2[31:16]};
                  r_cell_en   <= 1'b1;
                  r_state     <= S_ISSUE2;
               end else begin
                  r_rsp_data  <= w_lo;
                  r_rsp_tag   <= r_tag;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end
`else
               r_rsp_data  <= w_lo;
               r_rsp_tag   <= r_tag;
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESP;
`endif
            end
`ifdef SD_MUL_CTRL_HI_EN
            S_ISSUE2: r_state <= S_WAIT2;
            S_WAIT2: begin
               r_rsp_data  <= w_full[63:32];
               r_rsp_tag   <= r_tag;
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESP;
            end
`endif
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_nios2_gen2_0_cpu_mul_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sd_nios2_gen2_0_cpu_mul_ctrl
//
// Bench for sd_nios2_gen2_0_cpu_mul_ctrl. Contains a behavioural model of the
// 16x16 cell, a transaction-level reference (full 64-bit product, fixed
// latency per op) compared against the DUT every falling edge, and directed
// transactions with hand-computed results. Honors SD_MUL_CTRL_HI_EN.
// ---------------------------------------------------------------------------
module tb_sd_nios2_gen2_0_cpu_mul_ctrl;

`ifdef SD_MUL_CTRL_HI_EN
   localparam bit HI = 1'b1;
`else
   localparam bit HI = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_src1 = '0;
   logic [31:0] req_src2 = '0;
   logic        req_op = 1'b0;
   logic [3:0]  req_tag = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_tag;
   logic [31:0] cell_src1;
   logic [31:0] cell_src2;
   logic        cell_en;
   logic [31:0] cell_p1 = '0;
   logic [31:0] cell_p2 = '0;
   logic [31:0] cell_p3 = '0;

   int n_tests = 0;
   int n_fail  = 0;

   sd_nios2_gen2_0_cpu_mul_ctrl #(.TAG_W(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_src1(req_src1), .req_src2(req_src2), .req_op(req_op), .req_tag(req_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_tag(rsp_tag),
      .cell_src1(cell_src1), .cell_src2(cell_src2), .cell_en(cell_en),
      .cell_p1(cell_p1), .cell_p2(cell_p2), .cell_p3(cell_p3)
   );

   always #5 clk = ~clk;

   // Multiplier cell: registered partial products, frozen while cell_en = 0.
   always @(posedge clk) begin
      if (cell_en) begin
         cell_p1 <= 32'(cell_src1[15:0])  * 32'(cell_src2[15:0]);
         cell_p2 <= 32'(cell_src1[15:0])  * 32'(cell_src2[31:16]);
         cell_p3 <= 32'(cell_src1[31:16]) * 32'(cell_src2[15:0]);
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference ----------------
   typedef enum {M_IDLE, M_BUSY, M_RESP} mstate_t;
   mstate_t     m_st = M_IDLE;
   bit          m_armed = 1'b0;
   int          m_age = 0;
   int          m_lat = 3;
   bit          m_hi = 1'b0;
   logic [31:0] m_a = '0;
   logic [31:0] m_b = '0;
   logic [31:0] m_data = '0;
   logic [3:0]  m_tag = '0;

   always @(posedge clk) begin : model
      logic [63:0] prod;
      if (reset) begin
         m_st    <= M_IDLE;
         m_age   <= 0;
         m_armed <= 1'b1;
      end else begin
         case (m_st)
            M_IDLE: if (req_valid) begin
               prod   = 64'(req_src1) * 64'(req_src2);
               m_hi   <= HI && req_op;
               m_data <= (HI && req_op) ? prod[63:32] : prod[31:0];
               m_lat  <= (HI && req_op) ? 5 : 3;
               m_tag  <= req_tag;
               m_a    <= req_src1;
               m_b    <= req_src2;
               m_age  <= 1;
               m_st   <= M_BUSY;
            end
            M_BUSY: begin
               m_age <= m_age + 1;
               if (m_age + 1 >= m_lat) m_st <= M_RESP;
            end
            M_RESP: if (rsp_ready) m_st <= M_IDLE;
            default: m_st <= M_IDLE;
         endcase
      end
   end

   // Compare process: every falling edge once the model has seen reset.
   always @(negedge clk) begin
      if (m_armed) begin
         bit exp_en;
         exp_en = (m_st == M_BUSY) && (m_age == 1 || (m_hi && m_age == 3));
         check("req_ready", 64'(req_ready), 64'(m_st == M_IDLE));
         check("rsp_valid", 64'(rsp_valid), 64'(m_st == M_RESP));
         check("cell_en",   64'(cell_en),   64'(exp_en));
         if (m_st == M_RESP) begin
            check("rsp_data", 64'(rsp_data), 64'(m_data));
            check("rsp_tag",  64'(rsp_tag),  64'(m_tag));
         end
         if (exp_en && m_age == 1) begin
            check("cell_src1_pass1", 64'(cell_src1), 64'(m_a));
            check("cell_src2_pass1", 64'(cell_src2), 64'(m_b));
         end
         if (exp_en && m_age == 3) begin
            check("cell_src1_pass2", 64'(cell_src1), 64'({16'h0, m_a[31:16]}));
            check("cell_src2_pass2", 64'(cell_src2), 64'({16'h0, m_b[31:16]}));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for req_ready, presents one request, returns one cycle
   // after the accepting edge with req_valid dropped.
   task automatic send_req(input logic [31:0] a, input logic [31:0] b,
                           input bit op, input logic [3:0] tag);
      int guard = 0;
      while (!req_ready && guard < 20) begin
         step();
         guard++;
      end
      check("send_req_ready_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_src1  = a;
      req_src2  = b;
      req_op    = op;
      req_tag   = tag;
      step();
      req_valid = 1'b0;
   endtask

   // Called one cycle after the accept edge; counts cycles and cell_en pulses
   // until rsp_valid, checks against literals, then completes the handshake.
   task automatic wait_rsp(input string name, input logic [31:0] exp_d,
                           input logic [3:0] exp_tag, input int exp_lat,
                           input int exp_pulses, input bit release_rsp);
      int cyc    = 1;
      int pulses = 0;
      while (!rsp_valid && cyc < 20) begin
         if (cell_en) pulses++;
         step();
         cyc++;
      end
      check({name, "_latency"}, 64'(cyc), 64'(exp_lat));
      check({name, "_pulses"},  64'(pulses), 64'(exp_pulses));
      check({name, "_data"},    64'(rsp_data), 64'(exp_d));
      check({name, "_tag"},     64'(rsp_tag), 64'(exp_tag));
      if (release_rsp) begin
         rsp_ready = 1'b1;
         step();
         rsp_ready = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) step();
      reset = 1'b0;
      // Reset state.
      check("reset_req_ready", 64'(req_ready), 64'd1);
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_rsp_data",  64'(rsp_data),  64'd0);
      check("reset_rsp_tag",   64'(rsp_tag),   64'd0);
      check("reset_cell_en",   64'(cell_en),   64'd0);
      check("reset_cell_src1", 64'(cell_src1), 64'd0);
      check("reset_cell_src2", 64'(cell_src2), 64'd0);
      step();

      // Low word, small operands: 3 cycles, one pass.
      send_req(32'h0001_0002, 32'h0003_0004, 1'b0, 4'h5);
      wait_rsp("op0_small", 32'h000A_0008, 4'h5, 3, 1, 1'b1);

      // All-ones operands exercise the 33-bit cross-term sum.
      send_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'h1);
      wait_rsp("op0_ones", 32'h0000_0001, 4'h1, 3, 1, 1'b1);

      send_req(32'h0000_FFFF, 32'h0001_0000, 1'b0, 4'h2);
      wait_rsp("op0_mid", 32'hFFFF_0000, 4'h2, 3, 1, 1'b1);

`ifdef SD_MUL_CTRL_HI_EN
      send_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'h7);
      wait_rsp("op1_ones", 32'hFFFF_FFFE, 4'h7, 5, 2, 1'b1);

      send_req(32'h0001_0002, 32'h0003_0004, 1'b1, 4'hA);
      wait_rsp("op1_small", 32'h0000_0003, 4'hA, 5, 2, 1'b1);

      send_req(32'h8000_0000, 32'h0000_0002, 1'b1, 4'hC);
      wait_rsp("op1_carry", 32'h0000_0001, 4'hC, 5, 2, 1'b1);
`else
      send_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'h7);
      wait_rsp("op1_off_ones", 32'h0000_0001, 4'h7, 3, 1, 1'b1);

      send_req(32'h0001_0002, 32'h0003_0004, 1'b1, 4'hA);
      wait_rsp("op1_off_small", 32'h000A_0008, 4'hA, 3, 1, 1'b1);

      send_req(32'h8000_0000, 32'h0000_0002, 1'b1, 4'hC);
      wait_rsp("op1_off_carry", 32'h0000_0000, 4'hC, 3, 1, 1'b1);
`endif

      // Backpressure: response held 4 cycles while a new request waits.
      send_req(32'h0000_0005, 32'h0000_0007, 1'b0, 4'h3);
      wait_rsp("stall_first", 32'h0000_0023, 4'h3, 3, 1, 1'b0);
      req_valid = 1'b1;
      req_src1  = 32'h0000_0006;
      req_src2  = 32'h0000_0009;
      req_op    = 1'b0;
      req_tag   = 4'h9;
      for (int i = 0; i < 4; i++) begin
         check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
         check("stall_rsp_data",  64'(rsp_data),  64'h23);
         check("stall_rsp_tag",   64'(rsp_tag),   64'h3);
         check("stall_req_ready", 64'(req_ready), 64'd0);
         step();
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("stall_ready_after_hs", 64'(req_ready), 64'd1);
      check("stall_valid_after_hs", 64'(rsp_valid), 64'd0);
      step();
      req_valid = 1'b0;
      wait_rsp("stall_second", 32'h0000_0036, 4'h9, 3, 1, 1'b1);

      // Reset while in WAIT1: operation abandoned, no response ever.
      send_req(32'h1234_5678, 32'h0000_0010, 1'b0, 4'hE);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst_mid_req_ready", 64'(req_ready), 64'd1);
      check("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_mid_cell_en",   64'(cell_en),   64'd0);
      begin
         int seen = 0;
         for (int i = 0; i < 8; i++) begin
            if (rsp_valid) seen++;
            step();
         end
         check("rst_mid_no_rsp", 64'(seen), 64'd0);
      end

      // Normal operation resumes after the abandoned request.
      send_req(32'h0000_0100, 32'h0000_0100, 1'b0, 4'h4);
      wait_rsp("post_reset", 32'h0001_0000, 4'h4, 3, 1, 1'b1);

      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
